// File: rtl/axil_regtest_master_if.sv
`default_nettype none
// ============================================================================
// axil_regtest_master_if : AXI4-Lite bundle between the register-test master
//                          and the slave under test.
// Revision : 1.0
// ============================================================================
interface axil_regtest_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface
`default_nettype wire

// File: rtl/axil_regtest_master.sv
`default_nettype none
// ============================================================================
// axil_regtest_master : AXI4-Lite master running a write / read-back / compare
//                       sweep over consecutive registers with an arithmetic pattern.
// Revision : 1.0
// ============================================================================
module axil_regtest_master #(
   parameter int                            C_M_AXI_ADDR_WIDTH = 32,
   parameter int                            C_M_AXI_DATA_WIDTH = 32,
   parameter int                            C_NUM_REGS         = 4,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
   parameter int                            C_TIMEOUT          = 1024
) (
   input  wire                           ACLK,
   input  wire                           ARESETN,
   input  wire                           start,
   input  wire                           mode,
   input  wire [C_M_AXI_DATA_WIDTH-1:0]  seed,
   input  wire [C_M_AXI_DATA_WIDTH-1:0]  step,
   output logic                          busy,
   output logic                          done,
   output logic                          pass,
   output logic                          timeout,
   output logic [7:0]                    err_count,
   output logic [7:0]                    fail_index,
   output logic [C_M_AXI_DATA_WIDTH-1:0] fail_data,
   axil_regtest_master_if.master         m_axi
);
   localparam int                            DW          = C_M_AXI_DATA_WIDTH;
   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] c_ADDR_STEP = C_M_AXI_ADDR_WIDTH'(DW / 8);
   localparam logic [7:0]                    c_LAST_IDX  = 8'(C_NUM_REGS - 1);
   localparam logic [31:0]                   c_TMO_LAST  = 32'(C_TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_WA, S_WB, S_RA, S_RD, S_DONE} state_t;

   state_t                        state_q;
   logic                          mode_q;
   logic [DW-1:0]                 seed_q, step_q, data_q;
   logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
   logic [7:0]                    idx_q;
   logic [31:0]                   tmo_q;
   logic                          awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic                          busy_q, done_q, pass_q, timeout_q;
   logic [7:0]                    err_q, fail_index_q;
   logic [DW-1:0]                 fail_data_q;

   logic w_last, w_tmo, w_wa_fin, w_b_hs, w_r_hs, w_r_err, w_fin, w_abort, w_err_ev;
   logic [7:0] w_err_inc;

   assign w_last    = (idx_q == c_LAST_IDX);
   assign w_tmo     = (tmo_q == c_TMO_LAST);
   // Each channel is finished once its valid has dropped or is being accepted now.
   assign w_wa_fin  = (!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready);
   assign w_b_hs    = m_axi.bvalid && bready_q;
   assign w_r_hs    = m_axi.rvalid && rready_q;
   assign w_r_err   = (m_axi.rresp != 2'b00) || (m_axi.rdata != data_q);
   assign w_err_inc = (err_q == 8'hFF) ? 8'hFF : err_q + 8'd1;

   always_comb begin
      w_fin = 1'b0;
      case (state_q)
         S_WA:    w_fin = w_wa_fin;
         S_WB:    w_fin = w_b_hs;
         S_RA:    w_fin = arvalid_q && m_axi.arready;
         S_RD:    w_fin = w_r_hs;
         default: w_fin = 1'b0;
      endcase
   end

   assign w_abort  = busy_q && w_tmo && !w_fin;
   assign w_err_ev = w_abort
                   || (state_q == S_WB && w_b_hs && m_axi.bresp != 2'b00)
                   || (state_q == S_RD && w_r_hs && w_r_err);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q      <= S_IDLE;
         mode_q       <= 1'b0;
         seed_q       <= '0;
         step_q       <= '0;
         data_q       <= '0;
         addr_q       <= '0;
         idx_q        <= '0;
         tmo_q        <= '0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         timeout_q    <= 1'b0;
         err_q        <= '0;
         fail_index_q <= '0;
         fail_data_q  <= '0;
      end else begin
         tmo_q <= tmo_q + 32'd1;
         if (w_abort) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            tmo_q     <= '0;
            state_q   <= S_DONE;
         end else begin
            case (state_q)
               S_IDLE, S_DONE: begin
                  tmo_q <= '0;
                  if (start) begin
                     mode_q       <= mode;
                     seed_q       <= seed;
                     step_q       <= step;
                     data_q       <= seed;
                     addr_q       <= C_BASE_ADDR;
                     idx_q        <= '0;
                     err_q        <= '0;
                     fail_index_q <= '0;
                     fail_data_q  <= '0;
                     done_q       <= 1'b0;
                     pass_q       <= 1'b0;
                     timeout_q    <= 1'b0;
                     busy_q       <= 1'b1;
                     awvalid_q    <= 1'b1;
                     wvalid_q     <= 1'b1;
                     state_q      <= S_WA;
                  end
               end
               S_WA: begin
                  if (m_axi.awready) awvalid_q <= 1'b0;
                  if (m_axi.wready)  wvalid_q  <= 1'b0;
                  if (w_wa_fin) begin
                     bready_q <= 1'b1;
                     tmo_q    <= '0;
                     state_q  <= S_WB;
                  end
               end
               S_WB: begin
                  if (w_b_hs) begin
                     bready_q <= 1'b0;
                     tmo_q    <= '0;
                     if (!mode_q) begin
                        arvalid_q <= 1'b1;
                        state_q   <= S_RA;
                     end else if (w_last) begin
                        // Bulk mode rewinds the pattern for the read pass.
                        idx_q     <= '0;
                        addr_q    <= C_BASE_ADDR;
                        data_q    <= seed_q;
                        arvalid_q <= 1'b1;
                        state_q   <= S_RA;
                     end else begin
                        idx_q     <= idx_q + 8'd1;
                        addr_q    <= addr_q + c_ADDR_STEP;
                        data_q    <= data_q + step_q;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_WA;
                     end
                  end
               end
               S_RA: begin
                  if (m_axi.arready) begin
                     arvalid_q <= 1'b0;
                     rready_q  <= 1'b1;
                     tmo_q     <= '0;
                     state_q   <= S_RD;
                  end
               end
               S_RD: begin
                  if (w_r_hs) begin
                     rready_q <= 1'b0;
                     tmo_q    <= '0;
                     if (w_last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == 8'd0) && !w_r_err;
                        state_q <= S_DONE;
                     end else begin
                        idx_q  <= idx_q + 8'd1;
                        addr_q <= addr_q + c_ADDR_STEP;
                        data_q <= data_q + step_q;
                        if (mode_q) begin
                           arvalid_q <= 1'b1;
                           state_q   <= S_RA;
                        end else begin
                           awvalid_q <= 1'b1;
                           wvalid_q  <= 1'b1;
                           state_q   <= S_WA;
                        end
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end

         // Only the first error records details; response and timeout errors leave fail_data at 0.
         if (w_err_ev) begin
            err_q <= w_err_inc;
            if (err_q == 8'd0) begin
               fail_index_q <= idx_q;
               if (state_q == S_RD && !w_abort && m_axi.rresp == 2'b00)
                  fail_data_q <= m_axi.rdata;
            end
         end
      end
   end

   assign m_axi.awaddr  = addr_q;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.awvalid = awvalid_q;
   assign m_axi.wdata   = data_q;
   assign m_axi.wstrb   = '1;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.bready  = bready_q;
   assign m_axi.araddr  = addr_q;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.rready  = rready_q;

   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign timeout    = timeout_q;
   assign err_count  = err_q;
   assign fail_index = fail_index_q;
   assign fail_data  = fail_data_q;
endmodule
`default_nettype wire

// File: tb/tb_axil_regtest_master.sv
`default_nettype none
// ============================================================================
// tb_axil_regtest_master : directed bench with a 4-register memory slave that
//                          can flip data, return SLVERR, alias or stall.
// Revision : 1.0
// ============================================================================
module tb_axil_regtest_master;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mode  = 1'b0;
   logic [31:0] seed  = '0;
   logic [31:0] step  = '0;
   logic        busy, done, pass, timeout;
   logic [7:0]  err_count, fail_index;
   logic [31:0] fail_data;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_basic [0:3] = '{32'h0101FFFF, 32'hABCDFFF1, 32'h5699FFE3, 32'h0165FFD5};

   always #5 clk = ~clk;

   axil_regtest_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   axil_regtest_master #(
      .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_NUM_REGS(4),
      .C_BASE_ADDR(32'h0), .C_TIMEOUT(16)
   ) dut (
      .ACLK(clk), .ARESETN(rst_n), .start(start), .mode(mode), .seed(seed), .step(step),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
      .fail_index(fail_index), .fail_data(fail_data), .m_axi(bus)
   );

   // ---------------- slave model ----------------
   logic        hold_aw   = 1'b0;
   logic        alias_en  = 1'b0;
   int          flip_reg  = -1;
   int          bresp_reg = -1;
   int          rresp_reg = -1;
   logic [31:0] mem [0:3];
   logic [31:0] wr_addr_log [0:15];
   int          wr_cnt, rd_cnt;
   logic        aw_got, w_got;
   logic [31:0] aw_addr_q, w_data_q;

   assign bus.awready = !hold_aw;
   assign bus.wready  = 1'b1;
   assign bus.arready = 1'b1;

   wire        aw_hs   = bus.awvalid && bus.awready;
   wire        w_hs    = bus.wvalid && bus.wready;
   wire        ar_hs   = bus.arvalid && bus.arready;
   wire [31:0] cur_aw  = aw_got ? aw_addr_q : bus.awaddr;
   wire [31:0] cur_w   = w_got ? w_data_q : bus.wdata;
   wire        have_aw = aw_got || aw_hs;
   wire        have_w  = w_got || w_hs;

   function automatic int slot(input logic [31:0] a);
      slot = (alias_en && a[3:0] == 4'h8) ? 0 : int'(a[3:2]);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_got     <= 1'b0;
         w_got      <= 1'b0;
         bus.bvalid <= 1'b0;
         bus.bresp  <= 2'b00;
         bus.rvalid <= 1'b0;
         bus.rdata  <= '0;
         bus.rresp  <= 2'b00;
      end else begin
         if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
         if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
         if (have_aw && have_w && !bus.bvalid) begin
            mem[slot(cur_aw)]        <= cur_w;
            wr_addr_log[wr_cnt % 16] <= cur_aw;
            wr_cnt                   <= wr_cnt + 1;
            bus.bvalid               <= 1'b1;
            bus.bresp                <= (int'(cur_aw[3:2]) == bresp_reg) ? 2'b10 : 2'b00;
            aw_got                   <= 1'b0;
            w_got                    <= 1'b0;
         end else begin
            if (aw_hs) begin aw_got <= 1'b1; aw_addr_q <= bus.awaddr; end
            if (w_hs)  begin w_got  <= 1'b1; w_data_q  <= bus.wdata;  end
         end
         if (ar_hs && !bus.rvalid) begin
            bus.rvalid <= 1'b1;
            bus.rdata  <= mem[slot(bus.araddr)] ^ ((int'(bus.araddr[3:2]) == flip_reg) ? 32'h1 : 32'h0);
            bus.rresp  <= (int'(bus.araddr[3:2]) == rresp_reg) ? 2'b10 : 2'b00;
            rd_cnt     <= rd_cnt + 1;
         end
      end
   end

   initial begin wr_cnt = 0; rd_cnt = 0; end

   // ---------------- helpers ----------------
   task automatic do_sweep(input logic m, input logic [31:0] sd, input logic [31:0] st, output int cyc);
      mode = m; seed = sd; step = st; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; mode = 1'b0; seed = '0; step = '0;
      cyc = 0;
      while (!done && cyc < 200) begin @(posedge clk); #1; cyc++; end
      n_checks++; if (done !== 1'b1) $display("FAIL sweep_done got %b want 1 after %0d cycles", done, cyc); else n_pass++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0)        $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0)        $display("FAIL rst_done got %b want 0", done); else n_pass++;
      n_checks++; if (pass !== 1'b0)        $display("FAIL rst_pass got %b want 0", pass); else n_pass++;
      n_checks++; if (timeout !== 1'b0)     $display("FAIL rst_timeout got %b want 0", timeout); else n_pass++;
      n_checks++; if (err_count !== 8'd0)   $display("FAIL rst_err got %0d want 0", err_count); else n_pass++;
      n_checks++; if (fail_index !== 8'd0)  $display("FAIL rst_fidx got %0d want 0", fail_index); else n_pass++;
      n_checks++; if (fail_data !== 32'd0)  $display("FAIL rst_fdata got %h want 0", fail_data); else n_pass++;
      n_checks++; if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 5'b0)
         $display("FAIL rst_handshake got %b want 00000", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}); else n_pass++;
      n_checks++; if ({bus.awaddr, bus.wdata, bus.araddr} !== 96'd0)
         $display("FAIL rst_addr_data got %h want 0", {bus.awaddr, bus.wdata, bus.araddr}); else n_pass++;
      n_checks++; if ({bus.wstrb, bus.awprot, bus.arprot} !== 10'b1111_000_000)
         $display("FAIL rst_strb_prot got %b want 1111000000", {bus.wstrb, bus.awprot, bus.arprot}); else n_pass++;
   endtask

   task automatic test_basic();
      int cyc, w0, r0;
      w0 = wr_cnt; r0 = rd_cnt;
      do_sweep(1'b0, 32'h0101FFFF, 32'hAACBFFF2, cyc);
      n_checks++; if (cyc !== 16)          $display("FAIL basic_cycles got %0d want 16", cyc); else n_pass++;
      n_checks++; if (pass !== 1'b1)       $display("FAIL basic_pass got %b want 1", pass); else n_pass++;
      n_checks++; if (err_count !== 8'd0)  $display("FAIL basic_err got %0d want 0", err_count); else n_pass++;
      n_checks++; if (busy !== 1'b0 || timeout !== 1'b0) $display("FAIL basic_busy_tmo got %b%b want 00", busy, timeout); else n_pass++;
      n_checks++; if (rd_cnt - r0 !== 4)   $display("FAIL basic_reads got %0d want 4", rd_cnt - r0); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (mem[i] !== exp_basic[i]) $display("FAIL basic_mem%0d got %h want %h", i, mem[i], exp_basic[i]); else n_pass++;
         n_checks++; if (wr_addr_log[(w0 + i) % 16] !== 32'(i * 4))
            $display("FAIL basic_waddr%0d got %h want %h", i, wr_addr_log[(w0 + i) % 16], i * 4); else n_pass++;
      end
      repeat (5) @(posedge clk); #1;
      n_checks++; if (done !== 1'b1 || pass !== 1'b1) $display("FAIL basic_done_hold got %b%b want 11", done, pass); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int cyc;
      mode = 1'b1; seed = 32'h10; step = 32'h3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; mode = 1'b0; seed = '0; step = '0;
      n_checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_busy got %b%b want 10", busy, done); else n_pass++;
      cyc = 0;
      while (!done && cyc < 200) begin
         start = (cyc == 5);
         @(posedge clk); #1; cyc++;
      end
      start = 1'b0;
      n_checks++; if (cyc !== 16) $display("FAIL b2b_cycles got %0d want 16", cyc); else n_pass++;
      n_checks++; if (pass !== 1'b1) $display("FAIL b2b_pass got %b want 1", pass); else n_pass++;
      n_checks++; if ({mem[0], mem[1], mem[2], mem[3]} !== {32'h10, 32'h13, 32'h16, 32'h19})
         $display("FAIL b2b_mem got %h %h %h %h want 10 13 16 19", mem[0], mem[1], mem[2], mem[3]); else n_pass++;
   endtask

   task automatic test_bitflip();
      int cyc, r0;
      r0 = rd_cnt; flip_reg = 2;
      do_sweep(1'b0, 32'h0101FFFF, 32'hAACBFFF2, cyc);
      flip_reg = -1;
      n_checks++; if (err_count !== 8'd1)         $display("FAIL flip_err got %0d want 1", err_count); else n_pass++;
      n_checks++; if (fail_index !== 8'd2)        $display("FAIL flip_fidx got %0d want 2", fail_index); else n_pass++;
      n_checks++; if (fail_data !== 32'h5699FFE2) $display("FAIL flip_fdata got %h want 5699ffe2", fail_data); else n_pass++;
      n_checks++; if (pass !== 1'b0)              $display("FAIL flip_pass got %b want 0", pass); else n_pass++;
      n_checks++; if (rd_cnt - r0 !== 4)          $display("FAIL flip_reads got %0d want 4", rd_cnt - r0); else n_pass++;
   endtask

   task automatic test_resp_err();
      int cyc;
      bresp_reg = 1; rresp_reg = 3;
      do_sweep(1'b0, 32'h0101FFFF, 32'hAACBFFF2, cyc);
      bresp_reg = -1; rresp_reg = -1;
      n_checks++; if (err_count !== 8'd2)  $display("FAIL resp_err got %0d want 2", err_count); else n_pass++;
      n_checks++; if (fail_index !== 8'd1) $display("FAIL resp_fidx got %0d want 1", fail_index); else n_pass++;
      n_checks++; if (fail_data !== 32'd0) $display("FAIL resp_fdata got %h want 0", fail_data); else n_pass++;
      n_checks++; if (pass !== 1'b0)       $display("FAIL resp_pass got %b want 0", pass); else n_pass++;
   endtask

   task automatic test_alias();
      int cyc;
      alias_en = 1'b1;
      do_sweep(1'b0, 32'h0101FFFF, 32'hAACBFFF2, cyc);
      n_checks++; if (pass !== 1'b1 || err_count !== 8'd0)
         $display("FAIL alias0_result got pass=%b err=%0d want pass=1 err=0", pass, err_count); else n_pass++;
      do_sweep(1'b1, 32'h0101FFFF, 32'hAACBFFF2, cyc);
      alias_en = 1'b0;
      n_checks++; if (cyc !== 16)                 $display("FAIL alias1_cycles got %0d want 16", cyc); else n_pass++;
      n_checks++; if (err_count !== 8'd1)         $display("FAIL alias1_err got %0d want 1", err_count); else n_pass++;
      n_checks++; if (fail_index !== 8'd0)        $display("FAIL alias1_fidx got %0d want 0", fail_index); else n_pass++;
      n_checks++; if (fail_data !== 32'h5699FFE3) $display("FAIL alias1_fdata got %h want 5699ffe3", fail_data); else n_pass++;
      n_checks++; if (pass !== 1'b0)              $display("FAIL alias1_pass got %b want 0", pass); else n_pass++;
   endtask

   task automatic test_midsweep_reset();
      int cyc;
      mode = 1'b0; seed = 32'h0101FFFF; step = 32'hAACBFFF2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (!(bus.rready && bus.araddr == 32'h4) && cyc < 100) begin @(posedge clk); #1; cyc++; end
      n_checks++; if (!(bus.rready && bus.araddr == 32'h4)) $display("FAIL mrst_reach_rd1 got rready=%b araddr=%h want 1 4", bus.rready, bus.araddr); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++; if ({busy, done, pass, timeout} !== 4'b0) $display("FAIL mrst_status got %b want 0000", {busy, done, pass, timeout}); else n_pass++;
      n_checks++; if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 5'b0)
         $display("FAIL mrst_handshake got %b want 00000", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}); else n_pass++;
      n_checks++; if ({bus.awaddr, bus.wdata} !== 64'd0) $display("FAIL mrst_addr_data got %h want 0", {bus.awaddr, bus.wdata}); else n_pass++;
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (4) @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0 || bus.awvalid !== 1'b0) $display("FAIL mrst_idle got busy=%b awvalid=%b want 0 0", busy, bus.awvalid); else n_pass++;
      do_sweep(1'b0, 32'h0101FFFF, 32'hAACBFFF2, cyc);
      n_checks++; if (pass !== 1'b1 || err_count !== 8'd0 || cyc !== 16)
         $display("FAIL mrst_resweep got pass=%b err=%0d cyc=%0d want 1 0 16", pass, err_count, cyc); else n_pass++;
   endtask

   task automatic test_timeout();
      int cyc, aw_hi;
      hold_aw = 1'b1;
      mode = 1'b0; seed = 32'h0101FFFF; step = 32'h1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0; aw_hi = 0;
      while (!done && cyc < 100) begin
         if (bus.awvalid) aw_hi++;
         @(posedge clk); #1; cyc++;
      end
      hold_aw = 1'b0;
      n_checks++; if (aw_hi !== 16)         $display("FAIL tmo_awvalid_cycles got %0d want 16", aw_hi); else n_pass++;
      n_checks++; if (done !== 1'b1 || timeout !== 1'b1) $display("FAIL tmo_flags got done=%b timeout=%b want 1 1", done, timeout); else n_pass++;
      n_checks++; if (pass !== 1'b0)        $display("FAIL tmo_pass got %b want 0", pass); else n_pass++;
      n_checks++; if (fail_index !== 8'd0)  $display("FAIL tmo_fidx got %0d want 0", fail_index); else n_pass++;
      n_checks++; if (err_count !== 8'd1)   $display("FAIL tmo_err got %0d want 1", err_count); else n_pass++;
      n_checks++; if ({busy, bus.awvalid} !== 2'b00) $display("FAIL tmo_dropped got busy=%b awvalid=%b want 0 0", busy, bus.awvalid); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_bitflip();
      test_resp_err();
      test_alias();
      test_midsweep_reset();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end
endmodule
`default_nettype wire
